btn_nav_ctrl: RTL and testbench
===============================

BTN_NAV_CTRL -- requirements
Module: btn_nav_ctrl

Interface
REQ-001 SHALL have parameter DATADEPTH, default 16, number of addressable entries; the address range is 0..DATADEPTH-1.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4, the number of consecutive equal synchronized samples needed to change the debounced level.
REQ-003 SHALL have parameter REPEAT_DELAY, default 32, the number of cycles from a press event to the first auto-repeat event.
REQ-004 SHALL have parameter REPEAT_PERIOD, default 8, the number of cycles between successive auto-repeat events.
REQ-005 SHALL have port btn_clk, input, 1 bit: the clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port btn_up, input, 1 bit: raw asynchronous up button, active-high.
REQ-008 SHALL have port btn_dn, input, 1 bit: raw asynchronous down button, active-high.
REQ-009 SHALL have port address, output, 21 bits: the current navigation address, registered.
REQ-010 SHALL have port operation, output, 1 bit: a one-cycle pulse marking each address step, registered.
REQ-011 SHALL have port dir, output, 1 bit: direction of the last step (1 = up, 0 = down), registered.
REQ-012 SHALL have port held, output, 1 bit: high while the FSM is in HOLD or REPEAT, registered.

Function
REQ-013 SHALL pass each raw button through a 2-flop synchronizer before any other logic uses it.
REQ-014 SHALL change a debounced level only after DEBOUNCE_CYCLES consecutive synchronized samples differ from the current level.
REQ-015 SHALL reset the debounce counter whenever a sample equals the current debounced level.
REQ-016 SHALL implement an FSM with states IDLE, HOLD, REPEAT and LOCKOUT.
REQ-017 IDLE: if exactly one debounced button rises, SHALL emit one step event and go to HOLD with the hold counter cleared.
REQ-018 HOLD: if that button is still held after REPEAT_DELAY cycles, SHALL emit a step event and go to REPEAT.
REQ-019 REPEAT: SHALL emit a step event every REPEAT_PERIOD cycles while that button remains held.
REQ-020 HOLD/REPEAT: on release of the active button, SHALL go to IDLE with no event; release never generates a step.
REQ-021 Any state: if both debounced levels are high, SHALL go to LOCKOUT with no event.
REQ-022 LOCKOUT: SHALL stay until both debounced levels are low, then go to IDLE.
REQ-023 IDLE: if both buttons rise in the same cycle, SHALL go to LOCKOUT with no event.
REQ-024 On a step event, SHALL update address, set dir and raise operation for exactly one cycle, all on the same edge.
REQ-025 Up step: SHALL set address to 0 if address >= DATADEPTH-1, otherwise to address+1.
REQ-026 Down step: SHALL set address to DATADEPTH-1 if address == 0 or address > DATADEPTH-1, otherwise to address-1.
REQ-027 SHALL hold address and dir constant between events.
REQ-028 Latency: operation SHALL go high (3 + DEBOUNCE_CYCLES) rising edges after the first edge that samples the raw button high; 7 edges with defaults.
REQ-029 SHALL keep the hold counter wide enough for max(REPEAT_DELAY, REPEAT_PERIOD) and SHALL never let it overflow.

Reset
REQ-030 While rst is high, SHALL hold address = 0, operation = 0, dir = 1 and held = 0.
REQ-031 While rst is high, SHALL hold the FSM in IDLE and all synchronizer flops, debounced levels and counters at 0.
REQ-032 A button held across reset deassertion SHALL be treated as a new press, giving one event after the REQ-028 latency.
REQ-033 Reset asserted mid-HOLD or mid-REPEAT SHALL abort immediately with no further events.

Structure
REQ-034 SHALL place the FSM state encoding and the default parameter constants in shared package btn_nav_pkg.
REQ-035 SHALL implement synchronizer plus debounce as sub-module btn_debounce, instantiated once per button.

Verification
REQ-036 Reset then a clean btn_up press of 20 cycles -> one operation pulse 7 edges after press; address 0->1; dir=1; no event on release.
REQ-037 btn_dn from address 0 -> address 15, operation 1 cycle; a second press -> 14.
REQ-038 btn_up held 60 cycles from address 14 -> events at t0, t0+32, t0+40, t0+48, t0+56; addresses 15, 0, 1, 2, 3.
REQ-039 btn_up bouncing (toggles every 2 cycles for 10 cycles, then stable high) -> exactly one event.
REQ-040 btn_up held, then btn_dn pressed -> LOCKOUT with no further events; release both, press btn_dn -> one down step.
REQ-041 rst pulsed during REPEAT with btn_up still held -> address 0 during reset; one event 7 edges after rst falls.

Source files
------------

// File: rtl/btn_nav_pkg.sv
// btn_nav_pkg: shared FSM encoding, default parameters and address-step helper for btn_nav_ctrl
// Exports: nav_state_e, DEF_* defaults, ADDR_W, nav_next().
package btn_nav_pkg;
  localparam int ADDR_W              = 21;
  localparam int DEF_DATADEPTH       = 16;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_REPEAT_DELAY    = 32;
  localparam int DEF_REPEAT_PERIOD   = 8;
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCKOUT} nav_state_e;
  // Wrapping step; out-of-range addresses snap to the wrap target.
  function automatic logic [ADDR_W-1:0] nav_next(input logic [ADDR_W-1:0] a, input logic up, input int depth);
    logic [ADDR_W-1:0] last;
    last = ADDR_W'(depth - 1);
    return up ? ((a >= last) ? '0 : a + ADDR_W'(1))
              : ((a == '0 || a > last) ? last : a - ADDR_W'(1));
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer followed by a consecutive-sample debouncer
// Ports: btn_clk, rst (async, active-high), btn_raw (async input), level (debounced output).
module btn_debounce import btn_nav_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic btn_clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  always_comb begin
    sync_d  = {sync_q[0], btn_raw};
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) level_d = ~level_q;
      else cnt_d = cnt_q + CW'(1);
    end
  end
  always_ff @(posedge btn_clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end
  assign level = level_q;
endmodule

// File: rtl/btn_nav_ctrl.sv
// btn_nav_ctrl: up/down button navigator with debounce, auto-repeat and two-button lockout
// Ports: btn_clk, rst (async, active-high), btn_up/btn_dn (raw buttons),
//        address (current entry), operation (step pulse), dir (1=up), held (HOLD/REPEAT).
module btn_nav_ctrl import btn_nav_pkg::*; #(
  parameter int DATADEPTH       = DEF_DATADEPTH,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic              btn_clk,
  input  logic              rst,
  input  logic              btn_up,
  input  logic              btn_dn,
  output logic [ADDR_W-1:0] address,
  output logic              operation,
  output logic              dir,
  output logic              held
);
  localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW   = $clog2(HMAX + 1);
  logic              up_lvl, dn_lvl;
  logic              up_prev_q, dn_prev_q;
  nav_state_e        state_q, state_d;
  logic [HW-1:0]     hcnt_q, hcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              op_q, op_d, dir_q, dir_d, held_q, held_d;
  logic              step, step_up, act;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (.btn_clk(btn_clk), .rst(rst), .btn_raw(btn_up), .level(up_lvl));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (.btn_clk(btn_clk), .rst(rst), .btn_raw(btn_dn), .level(dn_lvl));
  // dir always holds the direction of the press that entered HOLD, so it names the active button.
  assign act = dir_q ? up_lvl : dn_lvl;
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    step    = 1'b0;
    step_up = dir_q;
    if (up_lvl && dn_lvl) state_d = LOCKOUT;
    else case (state_q)
      IDLE: begin
        if (up_lvl && !up_prev_q) begin
          step    = 1'b1;
          step_up = 1'b1;
          state_d = HOLD;
          hcnt_d  = '0;
        end else if (dn_lvl && !dn_prev_q) begin
          step    = 1'b1;
          step_up = 1'b0;
          state_d = HOLD;
          hcnt_d  = '0;
        end
      end
      HOLD: begin
        if (!act) state_d = IDLE;
        else if (hcnt_q == HW'(REPEAT_DELAY - 1)) begin
          step    = 1'b1;
          state_d = REPEAT;
          hcnt_d  = '0;
        end else hcnt_d = hcnt_q + HW'(1);
      end
      REPEAT: begin
        if (!act) state_d = IDLE;
        else if (hcnt_q == HW'(REPEAT_PERIOD - 1)) begin
          step   = 1'b1;
          hcnt_d = '0;
        end else hcnt_d = hcnt_q + HW'(1);
      end
      default: state_d = (!up_lvl && !dn_lvl) ? IDLE : LOCKOUT;
    endcase
    addr_d = step ? nav_next(addr_q, step_up, DATADEPTH) : addr_q;
    dir_d  = step ? step_up : dir_q;
    op_d   = step;
    held_d = (state_d == HOLD) || (state_d == REPEAT);
  end
  always_ff @(posedge btn_clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      hcnt_q    <= '0;
      addr_q    <= '0;
      op_q      <= 1'b0;
      dir_q     <= 1'b1;
      held_q    <= 1'b0;
      up_prev_q <= 1'b0;
      dn_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      addr_q    <= addr_d;
      op_q      <= op_d;
      dir_q     <= dir_d;
      held_q    <= held_d;
      up_prev_q <= up_lvl;
      dn_prev_q <= dn_lvl;
    end
  end
  assign address   = addr_q;
  assign operation = op_q;
  assign dir       = dir_q;
  assign held      = held_q;
endmodule

// File: tb/tb_btn_nav_ctrl.sv
// tb_btn_nav_ctrl: phase-table, corner-case and random checks of btn_nav_ctrl against a timeline model
module tb_btn_nav_ctrl;
  localparam int DEPTH = 16, DB = 4, RD = 32, RP = 8, MAXC = 4096;
  logic        btn_clk = 1'b0, rst = 1'b1, btn_up = 1'b0, btn_dn = 1'b0;
  logic [20:0] address;
  logic        operation, dir, held;
  int vectors = 0, miscompares = 0;
  btn_nav_ctrl #(.DATADEPTH(DEPTH), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .btn_clk(btn_clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn),
    .address(address), .operation(operation), .dir(dir), .held(held));
  always #5 btn_clk = ~btn_clk;
  // Model: raw samples per edge since reset; levels derived from sample windows; FSM from press timestamps.
  bit raw_u[MAXC], raw_d[MAXC], lv_u[MAXC], lv_d[MAXC];
  int n, m_addr, m_mode, m_tp, ops;
  bit m_dir, m_op, m_act_up;
  int op_edge[$];
  function automatic bit rawv(bit u, int i);
    return (i < 1) ? 1'b0 : (u ? raw_u[i] : raw_d[i]);
  endfunction
  function automatic bit lvv(bit u, int i);
    return (i < 1) ? 1'b0 : (u ? lv_u[i] : lv_d[i]);
  endfunction
  // Level flips once the last DB synchronized samples (raw delayed two edges) all disagree with it.
  function automatic bit new_level(bit u, int e);
    bit cur = lvv(u, e - 1);
    if (e - DB + 1 < 1) return cur;
    for (int j = 0; j < DB; j++) if (rawv(u, e - j - 2) == cur) return cur;
    return !cur;
  endfunction
  task automatic m_step(input bit up);
    m_op   = 1'b1;
    m_dir  = up;
    m_addr = up ? (m_addr + 1) % DEPTH : (m_addr + DEPTH - 1) % DEPTH;
  endtask
  task automatic model_edge(input bit u, input bit d);
    bit lu, ld, pu, pd, la;
    int k;
    n++;
    if (n >= MAXC) begin
      $display("FAIL model_capacity: edge %0d required below %0d", n, MAXC);
      $fatal(1);
    end
    raw_u[n] = u;
    raw_d[n] = d;
    lv_u[n]  = new_level(1'b1, n);
    lv_d[n]  = new_level(1'b0, n);
    lu = lvv(1'b1, n - 1); ld = lvv(1'b0, n - 1);
    pu = lvv(1'b1, n - 2); pd = lvv(1'b0, n - 2);
    m_op = 1'b0;
    if (lu && ld) m_mode = 2;
    else if (m_mode == 0) begin
      if (lu && !pu) begin m_step(1'b1); m_mode = 1; m_act_up = 1'b1; m_tp = n; end
      else if (ld && !pd) begin m_step(1'b0); m_mode = 1; m_act_up = 1'b0; m_tp = n; end
    end else if (m_mode == 1) begin
      la = m_act_up ? lu : ld;
      k  = n - m_tp;
      if (!la) m_mode = 0;
      else if (k == RD || (k > RD && (k - RD) % RP == 0)) m_step(m_act_up);
    end else if (!lu && !ld) m_mode = 0;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d, t=%0t)", nm, act, exp, n, $time);
    end
  endtask
  task automatic tick(input bit u, input bit d);
    btn_up = u;
    btn_dn = d;
    @(posedge btn_clk);
    #1;
    model_edge(u, d);
    chk("operation", operation, m_op);
    chk("address", address, m_addr);
    chk("dir", dir, m_dir);
    chk("held", held, m_mode == 1);
    if (operation === 1'b1) begin ops++; op_edge.push_back(n); end
  endtask
  task automatic do_reset(input int cyc);
    rst = 1'b1;
    #1;
    chk("rst_async_address", address, 0);
    chk("rst_async_operation", operation, 0);
    chk("rst_async_held", held, 0);
    for (int i = 0; i < cyc; i++) begin
      @(posedge btn_clk);
      #1;
      chk("rst_address", address, 0);
      chk("rst_operation", operation, 0);
      chk("rst_dir", dir, 1);
      chk("rst_held", held, 0);
    end
    n = 0; m_addr = 0; m_dir = 1'b1; m_mode = 0; m_op = 1'b0;
    rst = 1'b0;
  endtask
  typedef struct {bit up; bit dn; int cycles; int exp_ops; int exp_addr; bit exp_dir;} vec_t;
  vec_t tbl[$];
  initial begin
    int n0, o0;
    bit ru, rd;
    tbl = '{
      '{1, 0, 20, 1,  1, 1}, '{0, 0, 15, 0,  1, 1},
      '{0, 1, 20, 1,  0, 0}, '{0, 0, 15, 0,  0, 0},
      '{0, 1, 20, 1, 15, 0}, '{0, 0, 15, 0, 15, 0},
      '{0, 1, 20, 1, 14, 0}, '{0, 0, 15, 0, 14, 0},
      '{1, 0, 64, 5,  3, 1}, '{0, 0, 15, 0,  3, 1},
      '{1, 0,  2, 0,  3, 1}, '{0, 0,  2, 0,  3, 1}, '{1, 0, 2, 0, 3, 1},
      '{0, 0,  2, 0,  3, 1}, '{1, 0,  2, 0,  3, 1}, '{1, 0, 20, 1, 4, 1},
      '{0, 0, 15, 0,  4, 1},
      '{1, 0, 20, 1,  5, 1}, '{1, 1, 20, 0,  5, 1}, '{0, 0, 15, 0, 5, 1},
      '{0, 1, 20, 1,  4, 0}, '{0, 0, 15, 0,  4, 0}};
    do_reset(3);
    for (int i = 0; i < tbl.size(); i++) begin
      n0 = n;
      o0 = ops;
      op_edge.delete();
      for (int c = 0; c < tbl[i].cycles; c++) tick(tbl[i].up, tbl[i].dn);
      chk($sformatf("row%0d_ops", i), ops - o0, tbl[i].exp_ops);
      chk($sformatf("row%0d_address", i), address, tbl[i].exp_addr);
      chk($sformatf("row%0d_dir", i), dir, tbl[i].exp_dir);
      if (i == 0 && op_edge.size() > 0) chk("press_latency", op_edge[0] - n0, 7);
      if (i == 8 && op_edge.size() == 5) begin
        chk("repeat_t0", op_edge[0] - n0, 7);
        chk("repeat_first", op_edge[1] - op_edge[0], RD);
        chk("repeat_2", op_edge[2] - op_edge[0], RD + RP);
        chk("repeat_3", op_edge[3] - op_edge[0], RD + 2 * RP);
        chk("repeat_4", op_edge[4] - op_edge[0], RD + 3 * RP);
      end
    end
    for (int c = 0; c < 50; c++) tick(1'b1, 1'b0);
    chk("pre_reset_held", held, 1);
    do_reset(3);
    o0 = ops;
    op_edge.delete();
    for (int c = 0; c < 12; c++) tick(1'b1, 1'b0);
    chk("post_reset_ops", ops - o0, 1);
    if (op_edge.size() > 0) chk("post_reset_latency", op_edge[0], 7);
    chk("post_reset_address", address, 1);
    ru = 1'b0;
    rd = 1'b0;
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(15) == 0) ru = !ru;
      if ($urandom_range(19) == 0) rd = !rd;
      tick(ru, rd);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
